// File: rtl/pixel_readout_pkg.sv
// Shared definitions for the pixel readout block: parameter defaults,
// capture FSM encoding and the row-index type.
// No logic; imported by the interface and the top level.
package pixel_readout_pkg;

   localparam int DEF_DATA_W     = 8;
   localparam int DEF_FIFO_DEPTH = 4;
   localparam int DEF_SAMPLE_DLY = 2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_HOLD    = 2'd3
   } cap_state_e;

   typedef logic [1:0] row_t;

endpackage

// File: rtl/pixel_readout_if.sv
// Captured-pixel output stream: valid/ready handshake carrying {row, pixel}.
// No latency of its own; a beat transfers when out_valid and out_ready are both high.
// Backpressure: master holds out_data stable while out_valid=1 and out_ready=0.
// Ports: out_data (DATA_W+2), out_valid (master->slave), out_ready (slave->master).
interface pixel_readout_if
   import pixel_readout_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) ();

   logic [DATA_W+1:0] out_data;
   logic              out_valid;
   logic              out_ready;

   modport master (output out_data, output out_valid, input out_ready);
   modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/readout_fifo.sv
// Small synchronous FIFO with first-word fall-through head output.
// Latency: a push is visible on dout/empty the cycle after it is accepted.
// Backpressure: push on full is accepted only if a pop happens in the same cycle.
// Ports: clk, reset (sync, active-high), push/din, pop/dout, full, empty.
module readout_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = 1;
   localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];
   localparam logic [AW-1:0] PTR_ONE  = 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty = (count == '0);
   assign full  = (count == CNT_FULL);
   assign dout  = mem[rd_ptr];

   // A pop on a full FIFO frees the slot the push writes into (wr_ptr == rd_ptr),
   // and the popped word has already been presented this cycle.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/pixel_readout.sv
// Pixel array readout: DAC ramp generator plus per-strobe pixel capture into an output FIFO.
// Latency: capture SAMPLE_DLY+1 cycles after strobe rise; entry on out_data one cycle later.
// Backpressure: out_ready stalls the FIFO; captures on a full FIFO are dropped and flag overflow.
// Ports: clk, reset (sync, active-high), erase, convert, read0..read3, pix_data,
//        dac_code, overflow, miss, frame_done, stream (master: out_data/out_valid/out_ready).
module pixel_readout
   import pixel_readout_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int SAMPLE_DLY = DEF_SAMPLE_DLY
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              erase,
   input  logic              convert,
   input  logic              read0,
   input  logic              read1,
   input  logic              read2,
   input  logic              read3,
   input  logic [DATA_W-1:0] pix_data,
   output logic [DATA_W-1:0] dac_code,
   output logic              overflow,
   output logic              miss,
   output logic              frame_done,
   pixel_readout_if.master   stream
);

   localparam logic [1:0] IDLE    = ST_IDLE;
   localparam logic [1:0] WAIT    = ST_WAIT;
   localparam logic [1:0] CAPTURE = ST_CAPTURE;
   localparam logic [1:0] HOLD    = ST_HOLD;

   localparam int CNT_W = (SAMPLE_DLY > 1) ? $clog2(SAMPLE_DLY) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SAMPLE_DLY - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = 1;
   localparam logic [DATA_W-1:0] DAC_MAX  = '1;
   localparam logic [DATA_W-1:0] DAC_ONE  = 1;

   logic [1:0]       state;
   row_t             row_q;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       reads;
   logic [3:0]       reads_q;
   logic [3:0]       rise;
   row_t             rise_row;
   logic             strobe_hi;
   logic             push;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic             miss_set;
   logic             ovf_set;
   logic [DATA_W+1:0] fifo_dout;

   // ---------------- DAC ramp ----------------
   always_ff @(posedge clk) begin
      if (reset || !convert) dac_code <= '0;
      else if (dac_code != DAC_MAX) dac_code <= dac_code + DAC_ONE;
   end

   // ---------------- strobe edge detect ----------------
   assign reads = {read3, read2, read1, read0};

   // Tracked through reset as well, so a strobe already high when reset
   // releases looks "old" and is not taken as a rise.
   always_ff @(posedge clk) begin
      reads_q <= reads;
   end

   assign rise = reads & ~reads_q;

   // Lowest index wins when several strobes rise together.
   always_comb begin
      rise_row = '0;
      for (int i = 3; i >= 0; i--) begin
         if (rise[i]) rise_row = row_t'(i);
      end
   end

   assign strobe_hi = reads[row_q];

   // ---------------- capture FSM ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         row_q <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|rise) begin
                  state <= WAIT;
                  row_q <= rise_row;
                  cnt   <= '0;
               end
            end
            WAIT: begin
               if (!strobe_hi)           state <= IDLE;
               else if (cnt == CNT_LAST) state <= CAPTURE;
               else                      cnt   <= cnt + CNT_ONE;
            end
            CAPTURE: state <= HOLD;
            HOLD: begin
               if (!strobe_hi) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign push       = (state == CAPTURE);
   assign frame_done = push && (row_q == 2'd3);
   assign miss_set   = (state == WAIT) && !strobe_hi;

   // ---------------- output FIFO ----------------
   assign pop     = stream.out_valid && stream.out_ready;
   assign ovf_set = push && fifo_full && !pop;

   readout_fifo #(
      .WIDTH (DATA_W + 2),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   ({row_q, pix_data}),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign stream.out_data  = fifo_dout;
   assign stream.out_valid = !fifo_empty;

   // ---------------- sticky flags (set beats erase) ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow <= 1'b0;
         miss     <= 1'b0;
      end else begin
         if (ovf_set)    overflow <= 1'b1;
         else if (erase) overflow <= 1'b0;
         if (miss_set)   miss <= 1'b1;
         else if (erase) miss <= 1'b0;
      end
   end

endmodule

// File: doc/pixel_readout.md
PIXEL_READOUT -- requirements
Module: pixel_readout

Interface
REQ-001 Parameter DATA_W, 8, width of pixel ADC value and DAC ramp code.
REQ-002 Parameter FIFO_DEPTH, 4, output FIFO entries; power of two, >=2.
REQ-003 Parameter SAMPLE_DLY, 2, cycles from read strobe rise to pix_data sample; >=1.
REQ-004 clk  in  1  single clock; all state changes on posedge clk.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 erase  in  1  frame-start phase from pixel sequencer; clears sticky flags.
REQ-007 convert  in  1  conversion phase from pixel sequencer.
REQ-008 read0, read1, read2, read3  in  1 each  row-group read strobes from pixel sequencer.
REQ-009 pix_data  in  DATA_W  pixel bus value driven by the selected row group.
REQ-010 dac_code  out  DATA_W  ramp code to the comparator DAC / pixel counters.
REQ-011 out_data  out  DATA_W+2  FIFO head: {row[1:0], pixel[DATA_W-1:0]}.
REQ-012 out_valid  out  1  FIFO non-empty.
REQ-013 out_ready  in  1  downstream accepts out_data when high with out_valid.
REQ-014 overflow  out  1  sticky; a capture was dropped because the FIFO was full.
REQ-015 miss  out  1  sticky; a read strobe ended before its sample point.
REQ-016 frame_done  out  1  one-cycle pulse on the row-3 capture cycle.

Function
REQ-017 dac_code SHALL be 0 while convert=0, and SHALL increment by 1 on each cycle convert=1, saturating at 2^DATA_W-1.
REQ-018 dac_code SHALL return to 0 on the first cycle after convert falls.
REQ-019 Capture FSM states SHALL be IDLE, WAIT, CAPTURE and HOLD.
REQ-020 IDLE->WAIT SHALL occur on a read strobe rise (strobe high now, low last cycle); the row index SHALL be latched and delay count set to 0.
REQ-021 If several strobes rise together, the lowest index SHALL win.
REQ-022 WAIT SHALL count while the latched strobe stays high and go to CAPTURE when count reaches SAMPLE_DLY-1.
REQ-023 If the latched strobe falls in WAIT, the FSM SHALL go to IDLE with no push and set miss.
REQ-024 CAPTURE SHALL last exactly one cycle, push {row, pix_data} into the FIFO, then go to HOLD.
REQ-025 HOLD SHALL remain until the latched strobe is low, then go to IDLE; exactly one capture per strobe pulse.
REQ-026 frame_done SHALL be 1 exactly in the CAPTURE cycle with row=3, whether or not the push is dropped.
REQ-027 FIFO pop SHALL occur when out_valid and out_ready are both 1; out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-028 A pushed entry SHALL appear on out_data with out_valid=1 one cycle after CAPTURE if the FIFO was empty.
REQ-029 Push on full with simultaneous pop SHALL succeed; push on full without pop SHALL be dropped and set overflow.
REQ-030 Simultaneous push and pop on empty SHALL leave the pushed entry valid next cycle.
REQ-031 Pointers SHALL wrap modulo FIFO_DEPTH; the occupancy counter SHALL be $clog2(FIFO_DEPTH)+1 bits wide.
REQ-032 erase=1 SHALL clear overflow and miss, and SHALL NOT affect the FIFO contents or the FSM.
REQ-033 If erase=1 coincides with a flag-setting event, the set SHALL win.

Reset
REQ-034 reset SHALL force FSM=IDLE, FIFO empty, dac_code=0, out_valid=0, overflow=0, miss=0 and frame_done=0 on the next posedge.
REQ-035 When reset is asserted mid-capture, any pending sample SHALL be discarded; a strobe already high at reset release SHALL NOT be treated as a rise.

Structure
REQ-036 Package pixel_readout_pkg SHALL hold the DATA_W, FIFO_DEPTH and SAMPLE_DLY defaults, the FSM state enum, and the row-index typedef.
REQ-037 FIFO storage SHALL be a sub-module, readout_fifo, with push/pop/full/empty ports and a sync active-high reset.

Verification
REQ-038 With convert high for 300 cycles: dac_code runs 0..255, holds at 255 for 45 cycles, and is 0 on the cycle after convert falls.
REQ-039 With read0..read3 pulses of 5 cycles each, pix_data=0x11/0x22/0x33/0x44 and out_ready=1: outputs are 0x011, 0x122, 0x233, 0x344 in order, with one frame_done pulse.
REQ-040 With read1 held high for 1 cycle (SAMPLE_DLY=2): no push, miss=1; then erase pulse: miss=0.
REQ-041 With out_ready=0 and 6 read pulses: 4 entries are held, overflow=1, and the first 4 values drain in order once out_ready=1.
REQ-042 With FIFO full and a capture coinciding with a pop: no overflow, the count stays 4, and the new entry is last.
REQ-043 With reset asserted during WAIT and read2 held high through reset release: no push, FSM stays IDLE until read2 falls and rises again.
